// File: rtl/rv_muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: FUNCT3 opcodes, FSM states
// and the operand signedness class used for sign handling and result reuse.
package rv_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_MUL_SS = 3'd0,
    CLS_MUL_SU = 3'd1,
    CLS_MUL_UU = 3'd2,
    CLS_DIV_S  = 3'd3,
    CLS_DIV_U  = 3'd4
  } op_class_e;

  // MUL and MULH share a class: both come from the same signed full product.
  function automatic op_class_e op_class(input logic [2:0] funct3);
    case (funct3)
      F3_MUL, F3_MULH: op_class = CLS_MUL_SS;
      F3_MULHSU:       op_class = CLS_MUL_SU;
      F3_MULHU:        op_class = CLS_MUL_UU;
      F3_DIV, F3_REM:  op_class = CLS_DIV_S;
      default:         op_class = CLS_DIV_U;
    endcase
  endfunction

  function automatic logic a_signed(input op_class_e cls);
    a_signed = (cls == CLS_MUL_SS) || (cls == CLS_MUL_SU) || (cls == CLS_DIV_S);
  endfunction

  function automatic logic b_signed(input op_class_e cls);
    b_signed = (cls == CLS_MUL_SS) || (cls == CLS_DIV_S);
  endfunction

endpackage

// File: rtl/rv_muldiv_step.sv
// Combinational UNROLL-deep chain of shift-add multiply or restoring-divide steps
// over a shared 2*XLEN+1 accumulator ({hi/remainder, lo/quotient}).
module muldiv_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic              is_div,
  input  logic [XLEN-1:0]   operand,
  input  logic [2*XLEN:0]   acc_in,
  output logic [2*XLEN:0]   acc_out
);

  logic [2*XLEN:0] chain [0:UNROLL];

  assign chain[0] = acc_in;
  assign acc_out  = chain[UNROLL];

  genvar gi;
  generate
    for (gi = 0; gi < UNROLL; gi++) begin : g_step
      logic [XLEN:0]   mul_sum;
      logic [2*XLEN:0] div_shift;
      logic [XLEN:0]   div_trial;

      // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
      assign mul_sum   = chain[gi][2*XLEN:XLEN] + (chain[gi][0] ? {1'b0, operand} : '0);
      // Divide: shift left, keep the trial subtraction only if it did not go negative.
      assign div_shift = {chain[gi][2*XLEN-1:0], 1'b0};
      assign div_trial = div_shift[2*XLEN:XLEN] - {1'b0, operand};

      assign chain[gi+1] = is_div
        ? (div_trial[XLEN] ? div_shift : {div_trial, div_shift[XLEN-1:1], 1'b1})
        : {1'b0, mul_sum, chain[gi][XLEN-1:1]};
    end
  endgenerate

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: IDLE/CALC/FIN FSM, magnitude datapath and sign fixup.
// Define MULDIV_OPCACHE_EN to reuse the previous full product / quotient+remainder.
module rv_muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int RD_W   = 5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  input  logic [RD_W-1:0] RD_IN,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT,
  output logic [RD_W-1:0] RD_OUT
);

  localparam int NSTEP = XLEN / UNROLL;
  localparam int CW    = $clog2(NSTEP + 1);
  localparam int AW    = 2 * XLEN + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     acc_q, acc_d, step_acc;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [XLEN-1:0]   result_q, result_d, fin_result;

  op_class_e         in_cls;
  logic              in_div, in_sa, in_sb, special, cache_hit;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [AW-1:0]     special_acc, cache_acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    in_cls      = op_class(FUNCT3);
    in_div      = FUNCT3[2];
    in_sa       = a_signed(in_cls) && OPERAND_A[XLEN-1];
    in_sb       = b_signed(in_cls) && OPERAND_B[XLEN-1];
    abs_a       = in_sa ? -OPERAND_A : OPERAND_A;
    abs_b       = in_sb ? -OPERAND_B : OPERAND_B;
    special     = 1'b0;
    special_acc = '0;
    // Special cases preload the accumulator so the normal unsigned fixup yields the answer.
    if (in_div && (OPERAND_B == '0)) begin
      special     = 1'b1;
      special_acc = {1'b0, OPERAND_A, {XLEN{1'b1}}};
    end else if ((in_cls == CLS_DIV_S) && (OPERAND_A == MIN_INT) && (OPERAND_B == '1)) begin
      special     = 1'b1;
      special_acc = {{(XLEN+1){1'b0}}, MIN_INT};
    end else if (!in_div && ((OPERAND_A == '0) || (OPERAND_B == '0))) begin
      special     = 1'b1;
    end
  end

`ifdef MULDIV_OPCACHE_EN
  logic              cache_valid_q, cache_valid_d;
  logic [XLEN-1:0]   cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic [XLEN-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  op_class_e         cache_cls_q, cache_cls_d, op_cls_q, op_cls_d;
  logic [2*XLEN-1:0] cache_res_q, cache_res_d;

  assign cache_hit = cache_valid_q && (OPERAND_A == cache_a_q) &&
                     (OPERAND_B == cache_b_q) && (in_cls == cache_cls_q);
  assign cache_acc = {1'b0, cache_res_q};

  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_a_d     = cache_a_q;
    cache_b_d     = cache_b_q;
    cache_cls_d   = cache_cls_q;
    cache_res_d   = cache_res_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_cls_d      = op_cls_q;
    if ((state_q == IDLE) && START && !FLUSH) begin
      op_a_d   = OPERAND_A;
      op_b_d   = OPERAND_B;
      op_cls_d = in_cls;
    end else if ((state_q != IDLE) && FLUSH) begin
      cache_valid_d = 1'b0;
    end else if (state_q == FIN) begin
      cache_valid_d = 1'b1;
      cache_a_d     = op_a_q;
      cache_b_d     = op_b_q;
      cache_cls_d   = op_cls_q;
      cache_res_d   = acc_q[2*XLEN-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cache_valid_q <= 1'b0;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
      cache_cls_q   <= CLS_MUL_SS;
      cache_res_q   <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_cls_q      <= CLS_MUL_SS;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_a_q     <= cache_a_d;
      cache_b_q     <= cache_b_d;
      cache_cls_q   <= cache_cls_d;
      cache_res_q   <= cache_res_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_cls_q      <= op_cls_d;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_acc = '0;
`endif

  muldiv_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .is_div  (funct3_q[2]),
    .operand (opnd_q),
    .acc_in  (acc_q),
    .acc_out (step_acc)
  );

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (funct3_q)
      F3_MUL:                       fin_result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fin_result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fin_result = quo_fix;
      default:                      fin_result = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (START && !FLUSH) begin
          funct3_d = FUNCT3;
          rd_d     = RD_IN;
          count_d  = CW'(NSTEP);
          sign_a_d = in_sa;
          sign_b_d = in_sb;
          if (special) begin
            acc_d    = special_acc;
            sign_a_d = 1'b0;
            sign_b_d = 1'b0;
            state_d  = FIN;
          end else if (cache_hit) begin
            acc_d   = cache_acc;
            state_d = FIN;
          end else begin
            // Multiplier sits in the low half; dividend shifts out of it into the remainder.
            acc_d   = {{(XLEN+1){1'b0}}, in_div ? abs_a : abs_b};
            opnd_d  = in_div ? abs_b : abs_a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (FLUSH) begin
          state_d = IDLE;
        end else begin
          acc_d   = step_acc;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!FLUSH) result_d = fin_result;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
    end
  end

  // The FIN value is presented directly so DONE and RESULT line up in the same cycle.
  assign BUSY   = (state_q != IDLE);
  assign DONE   = (state_q == FIN) && !FLUSH;
  assign RESULT = DONE ? fin_result : result_q;
  assign RD_OUT = rd_q;

endmodule
